// File: rtl/gate_checker.sv
// Response checker for the NOT/NAND gate test: delays the expected gate values by
// LATENCY edges, compares them against the gate outputs and keeps a pass/fail tally.
module gate_checker #(
    parameter int NUM_CHECKS = 4,
    parameter int LATENCY    = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             in_not,
    input  logic             in1_nand,
    input  logic             in2_nand,
    input  logic             out_not,
    input  logic             out_nand,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] check_cnt_q, check_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] first_fail_q, first_fail_d;
    logic             mismatch_q, mismatch_d;

    logic exp_not_now, exp_nand_now;
    logic exp_not_cmp, exp_nand_cmp;
    logic check_fail;
    logic last_check;

    assign exp_not_now  = ~in_not;
    assign exp_nand_now = ~(in1_nand & in2_nand);

    // Expected-value delay line; with zero latency the compare uses this edge's values.
    generate
        if (LATENCY == 0) begin : g_no_delay
            assign exp_not_cmp  = exp_not_now;
            assign exp_nand_cmp = exp_nand_now;
        end else begin : g_delay
            logic [LATENCY-1:0] dl_not_q;
            logic [LATENCY-1:0] dl_nand_q;

            // NOTE: the delay line is a handful of flops, so it is reset like any other
            // state; only true RAM arrays are left unreset.
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    dl_not_q  <= '0;
                    dl_nand_q <= '0;
                end else begin
                    dl_not_q[0]  <= exp_not_now;
                    dl_nand_q[0] <= exp_nand_now;
                    for (int i = 1; i < LATENCY; i++) begin
                        dl_not_q[i]  <= dl_not_q[i-1];
                        dl_nand_q[i] <= dl_nand_q[i-1];
                    end
                end
            end

            assign exp_not_cmp  = dl_not_q[LATENCY-1];
            assign exp_nand_cmp = dl_nand_q[LATENCY-1];
        end
    endgenerate

    // Case-inequality so an X or Z on a gate output is reported as a failure.
    assign check_fail = (out_not !== exp_not_cmp) || (out_nand !== exp_nand_cmp);
    assign last_check = (check_cnt_q == LAST_IDX);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: if (last_check) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_CHECK);
        done     = (state_q == ST_DONE);
        all_pass = (state_q == ST_DONE) && (fail_cnt_q == '0);
    end

    always_comb begin
        check_cnt_d  = check_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        mismatch_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    check_cnt_d  = '0;
                    fail_cnt_d   = '0;
                    first_fail_d = ALL_ONES;
                end
            end
            ST_CHECK: begin
                check_cnt_d = check_cnt_q + 1'b1;
                if (check_fail) begin
                    mismatch_d = 1'b1;
                    if (fail_cnt_q != ALL_ONES) fail_cnt_d = fail_cnt_q + 1'b1;
                    if (first_fail_q == ALL_ONES) first_fail_d = check_cnt_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            check_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= ALL_ONES;
            mismatch_q   <= 1'b0;
        end else begin
            check_cnt_q  <= check_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            mismatch_q   <= mismatch_d;
        end
    end

    assign check_count = check_cnt_q;
    assign fail_count  = fail_cnt_q;
    assign first_fail  = first_fail_q;
    assign mismatch    = mismatch_q;

endmodule

// File: doc/gate_checker.md
Name: gate_checker

Overview:
- Response-side companion to the gate stimulus generator in the compuertas test environment.
- Samples the stimulus applied to the NOT and NAND gates and the gates' outputs on every clock edge.
- Computes expected results and compares them, after a configurable pipeline latency, against the gate outputs.
- Counts checks and failures, then reports a pass/fail verdict when the run completes.

Parameters:
- NUM_CHECKS, 4, number of compares per run (1..2^CNT_W-2).
- LATENCY, 1, edges between stimulus sample and the matching DUT output (0..4).
- CNT_W, 8, width of the counters and the fail index.

Ports:
- clk  input  1  system clock; all sampling on the rising edge.
- reset_L  input  1  asynchronous reset, active-low.
- start  input  1  begins a run; sampled only in IDLE or DONE.
- in_not  input  1  stimulus driven to the NOT gate.
- in1_nand  input  1  NAND stimulus, operand A.
- in2_nand  input  1  NAND stimulus, operand B.
- out_not  input  1  NOT gate output under test.
- out_nand  input  1  NAND gate output under test.
- busy  output  1  high while in CHECK.
- done  output  1  high in DONE; held until restart or reset.
- all_pass  output  1  valid while done=1; 1 when fail_count==0.
- mismatch  output  1  one-cycle pulse for each failing check.
- check_count  output  CNT_W  number of checks performed in the current run.
- fail_count  output  CNT_W  number of failing checks; saturates at all-ones.
- first_fail  output  CNT_W  index of the first failing check; all-ones means none.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - State goes to IDLE.
  - busy, done, all_pass, mismatch, check_count and fail_count go to 0.
  - first_fail goes to all-ones.
  - Expected-value delay line is cleared to 0.
  - Reset mid-run aborts the run immediately; there is no partial verdict.
- Expected values:
  - exp_not = ~in_not; exp_nand = ~(in1_nand & in2_nand).
  - Both are pushed into a LATENCY-deep shift register on every edge, in all states.
  - With LATENCY=0, the compare uses the current-edge combinational expected values.
- FSM states: IDLE, CHECK, DONE.
  - IDLE: start=1 at an edge clears check_count, fail_count and mismatch, sets first_fail to all-ones, and moves to CHECK.
  - CHECK: compare k (k = 0..NUM_CHECKS-1) happens at edge start+1+k. It checks out_not/out_nand against the expected values from the stimulus sampled at edge start+1+k-LATENCY.
  - CHECK: check_count increments at each compare. start is ignored in CHECK.
  - After compare NUM_CHECKS-1, the FSM moves to DONE. At that same edge, done becomes 1 and all_pass = (final fail_count==0).
  - DONE: outputs hold. start=1 restarts exactly as from IDLE, with done and all_pass cleared at that edge.
- Failure rules:
  - A check fails if either output differs from its expected value.
  - Any X or Z on out_not or out_nand also counts as a failure (case-inequality).
  - On a failure: fail_count++ (saturating), mismatch=1 for the following cycle, and first_fail = k only if it is still all-ones.
  - mismatch is 0 on every edge with no failing check, including outside CHECK.

Test Plan:
- Correct gate models, LATENCY=1, NUM_CHECKS=4, in_not 0,1,0,1 and NAND (0,1),(1,0),(0,1),(1,0) from the start edge -> done=1 after 4 checks; check_count=4, fail_count=0, all_pass=1, first_fail=8'hFF, mismatch never high.
- Same stimulus with out_not stuck at 0 -> checks 0 and 2 fail; fail_count=2, first_fail=0, all_pass=0, two single-cycle mismatch pulses.
- out_nand driven as an AND only on check 1 -> fail_count=1, first_fail=1, all_pass=0.
- reset_L pulsed low during check 2 -> all outputs 0 and first_fail=8'hFF immediately, without waiting for a clock edge. A new start then gives a clean 4-check pass.
- start held high throughout CHECK -> no restart; run ends at check_count=4. start in DONE -> counters cleared, second run completes.
- out_nand=X on check 3, LATENCY=0 -> that check is counted as a failure; fail_count=1, first_fail=3.
